// File: rtl/riscv_pkg.sv
// Shared write-back types: source identifiers and the buffered write-back entry layout.
package riscv_pkg;

  localparam int unsigned XLEN_DEF       = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 5;
  localparam int unsigned STARVE_W       = 4;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_LSU  = 2'd2
  } wb_src_e;

  typedef struct packed {
    logic                      valid;
    logic [ADDR_WIDTH_DEF-1:0] rd;
    logic [XLEN_DEF-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/wb_slot.sv
// Single-entry write-back buffer for one source; refills in the same cycle it drains.
module wb_slot
  import riscv_pkg::*;
#(
  parameter type entry_t = wb_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  entry_t req,
  input  logic   grant,
  output logic   ready_c,
  output entry_t entry
);

  assign ready_c = !entry.valid || grant;

  // Accept takes precedence over drain so a granted slot can be refilled without a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry.valid <= 1'b0;
    end else if (req.valid && ready_c) begin
      entry <= req;
    end else if (grant) begin
      entry.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU and LSU write-back buffers onto the single register-file write port,
// LSU-first with a starvation guard for the ALU, and answers decode hazard queries.
module regfile_wb_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN         = XLEN_DEF,
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  input  logic [ADDR_WIDTH-1:0] q_addr1,
  input  logic [ADDR_WIDTH-1:0] q_addr2,
  output logic                  q_pend1,
  output logic                  q_pend2
);

  // Same layout as riscv_pkg::wb_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] rd;
    logic [XLEN-1:0]       data;
  } slot_entry_t;

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  slot_entry_t         alu_req, lsu_req;
  slot_entry_t         alu_e, lsu_e;
  wb_src_e             grant_c;
  logic                alu_grant, lsu_grant;
  logic [STARVE_W-1:0] starve_q, starve_d;

  assign alu_req = '{valid: alu_valid, rd: alu_rd, data: alu_data};
  assign lsu_req = '{valid: lsu_valid, rd: lsu_rd, data: lsu_data};

  wb_slot #(.entry_t(slot_entry_t)) u_alu_slot (
    .clk     (clk),
    .rst     (rst),
    .req     (alu_req),
    .grant   (alu_grant),
    .ready_c (alu_ready),
    .entry   (alu_e)
  );

  wb_slot #(.entry_t(slot_entry_t)) u_lsu_slot (
    .clk     (clk),
    .rst     (rst),
    .req     (lsu_req),
    .grant   (lsu_grant),
    .ready_c (lsu_ready),
    .entry   (lsu_e)
  );

  // LSU wins unless the ALU has already waited STARVE_LIMIT consecutive cycles.
  always_comb begin
    grant_c = SRC_NONE;
    if (lsu_e.valid && !(alu_e.valid && (starve_q == STARVE_MAX))) begin
      grant_c = SRC_LSU;
    end else if (alu_e.valid) begin
      grant_c = SRC_ALU;
    end
  end

  assign alu_grant = (grant_c == SRC_ALU);
  assign lsu_grant = (grant_c == SRC_LSU);

  always_comb begin
    starve_d = starve_q;
    if (!alu_e.valid || alu_grant) begin
      starve_d = '0;
    end else if (starve_q < STARVE_MAX) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  // Register-file drive; rd 0 entries drain without a write.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    unique case (grant_c)
      SRC_ALU: begin
        rf_waddr = alu_e.rd;
        rf_wdata = alu_e.data;
      end
      SRC_LSU: begin
        rf_waddr = lsu_e.rd;
        rf_wdata = lsu_e.data;
      end
      default: ;
    endcase
    rf_we = (grant_c != SRC_NONE) && (rf_waddr != '0);
  end

  function automatic logic pend_hit(input slot_entry_t a, input slot_entry_t l,
                                    input logic [ADDR_WIDTH-1:0] addr);
    pend_hit = (addr != '0) &&
               ((a.valid && (a.rd == addr)) || (l.valid && (l.rd == addr)));
  endfunction

  assign q_pend1 = pend_hit(alu_e, lsu_e, q_addr1);
  assign q_pend2 = pend_hit(alu_e, lsu_e, q_addr2);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a behavioural model of the two write-back buffers.
module tb_regfile_wb_arbiter;

  localparam int LIMIT = 4;

  logic        clk, rst;
  logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd, rf_waddr, q_addr1, q_addr2;
  logic [31:0] alu_data, lsu_data, rf_wdata;
  logic        rf_we, q_pend1, q_pend2;

  int errors = 0;
  int checks = 0;

  regfile_wb_arbiter #(.XLEN(32), .ADDR_WIDTH(5), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .q_pend1(q_pend1), .q_pend2(q_pend2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: index 0 = ALU buffer, 1 = LSU buffer; m_wait = consecutive cycles ALU waited.
  bit          m_v[2];
  logic [4:0]  m_rd[2];
  logic [31:0] m_data[2];
  int          m_wait;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    if (m_v[0] && m_v[1]) return (m_wait >= LIMIT) ? 0 : 1;
    if (m_v[1]) return 1;
    if (m_v[0]) return 0;
    return -1;
  endfunction

  function automatic bit model_pend(input logic [4:0] a);
    return (a != 0) && ((m_v[0] && m_rd[0] == a) || (m_v[1] && m_rd[1] == a));
  endfunction

  task automatic compare_model();
    int g;
    bit exp_we;
    logic [4:0] exp_addr;
    logic [31:0] exp_data;
    g = model_grant();
    exp_addr = (g >= 0) ? m_rd[g] : 5'd0;
    exp_data = (g >= 0) ? m_data[g] : 32'd0;
    exp_we   = (g >= 0) && (m_rd[g] != 0);
    chk("m_rf_we", 64'(rf_we), 64'(exp_we));
    chk("m_rf_waddr", 64'(rf_waddr), 64'(exp_addr));
    chk("m_rf_wdata", 64'(rf_wdata), 64'(exp_data));
    chk("m_alu_ready", 64'(alu_ready), 64'(!m_v[0] || g == 0));
    chk("m_lsu_ready", 64'(lsu_ready), 64'(!m_v[1] || g == 1));
    chk("m_q_pend1", 64'(q_pend1), 64'(model_pend(q_addr1)));
    chk("m_q_pend2", 64'(q_pend2), 64'(model_pend(q_addr2)));
  endtask

  task automatic model_update();
    int g;
    bit acc_a, acc_l;
    g = model_grant();
    if (rst) begin
      m_v[0] = 0; m_v[1] = 0; m_wait = 0;
      return;
    end
    acc_a = alu_valid && (!m_v[0] || g == 0);
    acc_l = lsu_valid && (!m_v[1] || g == 1);
    m_wait = (m_v[0] && g != 0) ? ((m_wait < LIMIT) ? m_wait + 1 : LIMIT) : 0;
    if (acc_a) begin m_v[0] = 1; m_rd[0] = alu_rd; m_data[0] = alu_data; end
    else if (g == 0) m_v[0] = 0;
    if (acc_l) begin m_v[1] = 1; m_rd[1] = lsu_rd; m_data[1] = lsu_data; end
    else if (g == 1) m_v[1] = 0;
  endtask

  task automatic negcheck(); @(negedge clk); compare_model(); endtask
  task automatic adv();      @(posedge clk); model_update(); #1; endtask
  task automatic cyc();      negcheck(); adv(); endtask

  initial begin
    rst = 1; alu_valid = 0; lsu_valid = 0; alu_rd = 0; lsu_rd = 0;
    alu_data = 0; lsu_data = 0; q_addr1 = 0; q_addr2 = 0;
    m_v[0] = 0; m_v[1] = 0; m_wait = 0;
    repeat (2) adv();
    rst = 0;

    // State right after reset.
    q_addr1 = 5'd3; q_addr2 = 5'd7;
    negcheck();
    chk("rst_rf_we", 64'(rf_we), 64'd0);
    chk("rst_alu_ready", 64'(alu_ready), 64'd1);
    chk("rst_lsu_ready", 64'(lsu_ready), 64'd1);
    chk("rst_q_pend1", 64'(q_pend1), 64'd0);
    chk("rst_q_pend2", 64'(q_pend2), 64'd0);
    adv();
    q_addr1 = 0; q_addr2 = 0;

    // ALU-only single write.
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    negcheck();
    chk("alu1_ready_accept", 64'(alu_ready), 64'd1);
    adv();
    alu_valid = 0;
    negcheck();
    chk("alu1_we", 64'(rf_we), 64'd1);
    chk("alu1_waddr", 64'(rf_waddr), 64'd5);
    chk("alu1_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    chk("alu1_ready", 64'(alu_ready), 64'd1);
    adv();

    // LSU write to x0 drains without a write.
    lsu_valid = 1; lsu_rd = 5'd0; lsu_data = 32'h1234;
    cyc();
    lsu_valid = 0;
    negcheck();
    chk("x0_we", 64'(rf_we), 64'd0);
    chk("x0_lsu_ready", 64'(lsu_ready), 64'd1);
    adv();
    negcheck();
    chk("x0_lsu_ready_next", 64'(lsu_ready), 64'd1);
    chk("x0_we_next", 64'(rf_we), 64'd0);
    adv();

    // Back-to-back ALU stream rd 1,2,3.
    alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h11;
    cyc();
    for (int i = 2; i <= 4; i++) begin
      if (i <= 3) begin alu_rd = 5'(i); alu_data = 32'(i * 17); end
      else alu_valid = 0;
      negcheck();
      chk("stream_we", 64'(rf_we), 64'd1);
      chk("stream_waddr", 64'(rf_waddr), 64'(i - 1));
      chk("stream_ready", 64'(alu_ready), 64'd1);
      adv();
    end

    // Continuous contention: four LSU grants then one ALU grant, repeating.
    alu_valid = 1; alu_rd = 5'd10; lsu_valid = 1; lsu_rd = 5'd20;
    alu_data = $urandom; lsu_data = $urandom;
    cyc();
    for (int i = 0; i < 10; i++) begin
      alu_data = $urandom; lsu_data = $urandom;
      negcheck();
      chk("starve_pattern", 64'(rf_waddr), (i % 5 == 4) ? 64'd10 : 64'd20);
      adv();
    end
    alu_valid = 0; lsu_valid = 0;
    repeat (3) cyc();

    // Hazard query on an ALU entry blocked by LSU traffic.
    alu_valid = 1; alu_rd = 5'd7; lsu_valid = 1; lsu_rd = 5'd9;
    cyc();
    alu_valid = 0; q_addr1 = 5'd7; q_addr2 = 5'd0;
    negcheck();
    chk("haz_waddr", 64'(rf_waddr), 64'd9);
    chk("haz_q_pend1", 64'(q_pend1), 64'd1);
    chk("haz_q_pend2", 64'(q_pend2), 64'd0);
    chk("haz_alu_ready", 64'(alu_ready), 64'd0);
    adv();
    lsu_valid = 0; q_addr1 = 0;
    repeat (3) cyc();

    // Reset with both buffers full discards them.
    alu_valid = 1; alu_rd = 5'd4; lsu_valid = 1; lsu_rd = 5'd6;
    cyc();
    rst = 1;
    cyc();
    rst = 0; alu_valid = 0; lsu_valid = 0; q_addr1 = 5'd4; q_addr2 = 5'd6;
    negcheck();
    chk("rstfull_we", 64'(rf_we), 64'd0);
    chk("rstfull_alu_ready", 64'(alu_ready), 64'd1);
    chk("rstfull_lsu_ready", 64'(lsu_ready), 64'd1);
    chk("rstfull_q_pend1", 64'(q_pend1), 64'd0);
    chk("rstfull_q_pend2", 64'(q_pend2), 64'd0);
    chk("rstfull_starve", 64'(dut.starve_q), 64'd0);
    adv();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 99) < 2);
      alu_valid = ($urandom_range(0, 99) < 65);
      lsu_valid = ($urandom_range(0, 99) < 55);
      alu_rd    = 5'($urandom_range(0, 7));
      lsu_rd    = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      lsu_data  = $urandom;
      q_addr1   = 5'($urandom_range(0, 7));
      q_addr2   = 5'($urandom_range(0, 7));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
